// File: rtl/uart_rx_ctrl_if.sv
// Bundle between the UART receive sequencer and its neighbours: the baud
// counter controls it drives and the received-byte outputs it presents.
interface uart_rx_ctrl_if #(
  parameter int Width = 15
);
  logic             cnt_flag_i;
  logic             cnt_en_o;
  logic             cnt_clr_o;
  logic [Width-1:0] cnt_vmax_o;
  logic [7:0]       data_o;
  logic             valid_o;
  logic             frame_err_o;
  logic             parity_err_o;
  logic             busy_o;

  modport master (
    input  cnt_flag_i,
    output cnt_en_o, cnt_clr_o, cnt_vmax_o,
    output data_o, valid_o, frame_err_o, parity_err_o, busy_o
  );

  modport slave (
    output cnt_flag_i,
    input  cnt_en_o, cnt_clr_o, cnt_vmax_o,
    input  data_o, valid_o, frame_err_o, parity_err_o, busy_o
  );
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: frame FSM that drives the external baud counter and
// samples each bit mid-period. Define RX_PARITY_EN to add an even-parity bit.
module uart_rx_ctrl #(
  parameter int Width    = 15,
  parameter int BitTicks = 5208,
  parameter int DataBits = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 rx_i,
  uart_rx_ctrl_if.master       bus
);
  localparam logic [Width-1:0] HALF = Width'(BitTicks / 2 - 1);
  localparam logic [Width-1:0] FULL = Width'(BitTicks - 1);
  localparam logic [3:0]       LAST = 4'(DataBits - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

  state_e              state_q, state_d;
  logic                sync1_q, sync2_q;
  logic [DataBits-1:0] shift_q, shift_d;
  logic [3:0]          idx_q, idx_d;
  logic [7:0]          data_q, data_d;
  logic                valid_q, valid_d;
  logic                ferr_q, ferr_d;
  logic                rx_s, tick;
  logic                cnt_en, cnt_clr;
  logic [Width-1:0]    cnt_vmax;
`ifdef RX_PARITY_EN
  logic                perr_q, perr_d;
  logic                pend_q, pend_d;
`endif

  assign rx_s = sync2_q;
  assign tick = cnt_en & bus.cnt_flag_i;

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    idx_d    = idx_q;
    data_d   = data_q;
    valid_d  = 1'b0;
    ferr_d   = ferr_q;
`ifdef RX_PARITY_EN
    perr_d   = perr_q;
    pend_d   = pend_q;
`endif
    cnt_clr  = 1'b0;
    cnt_en   = 1'b1;
    cnt_vmax = FULL;
    case (state_q)
      IDLE: begin
        cnt_clr  = 1'b1;
        cnt_en   = 1'b0;
        cnt_vmax = HALF;
        if (!rx_s) state_d = START;
      end
      START: begin
        cnt_vmax = HALF;
        if (tick) begin
          // A high line at mid start bit was a glitch, not a frame.
          if (!rx_s) begin
            state_d = DATA;
            idx_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (tick) begin
          shift_d = {rx_s, shift_q[DataBits-1:1]};
          idx_d   = idx_q + 4'd1;
          if (idx_q == LAST) begin
`ifdef RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef RX_PARITY_EN
      PARITY: begin
        if (tick) begin
          pend_d  = ^{shift_q, rx_s};
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (tick) begin
          data_d  = 8'(shift_q);
          ferr_d  = ~rx_s;
          valid_d = 1'b1;
`ifdef RX_PARITY_EN
          perr_d  = pend_q;
`endif
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      shift_q <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef RX_PARITY_EN
      perr_q  <= 1'b0;
      pend_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sync1_q <= rx_i;
      sync2_q <= sync1_q;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
`ifdef RX_PARITY_EN
      perr_q  <= perr_d;
      pend_q  <= pend_d;
`endif
    end
  end

  assign bus.cnt_en_o     = cnt_en;
  assign bus.cnt_clr_o    = cnt_clr;
  assign bus.cnt_vmax_o   = cnt_vmax;
  assign bus.busy_o       = (state_q != IDLE);
  assign bus.data_o       = data_q;
  assign bus.valid_o      = valid_q;
  assign bus.frame_err_o  = ferr_q;
`ifdef RX_PARITY_EN
  assign bus.parity_err_o = perr_q;
`else
  assign bus.parity_err_o = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: drives serial frames into the controller with a
// baud counter model attached and compares received bytes to a frame queue.
module tb_uart_rx_ctrl;
  localparam int W  = 15;
  localparam int BT = 16;
  localparam int DB = 8;

  typedef struct packed {
    logic [7:0] d;
    logic       f;
    logic       p;
  } frm_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx  = 1'b1;
  logic [W-1:0] cnt_q = '0;

  int tests = 0;
  int fails = 0;

  frm_t exp_q[$];
  frm_t got_q[$];

  uart_rx_ctrl_if #(.Width(W)) bus ();

  uart_rx_ctrl #(.Width(W), .BitTicks(BT), .DataBits(DB)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .rx_i  (rx),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // External baud counter: clear wins, wraps to zero at terminal count.
  assign bus.cnt_flag_i = (cnt_q == bus.cnt_vmax_o);
  always @(posedge clk) begin
    if (bus.cnt_clr_o)      cnt_q <= '0;
    else if (bus.cnt_en_o)  cnt_q <= bus.cnt_flag_i ? '0 : cnt_q + 1'b1;
  end

  always @(negedge clk) begin
    if (bus.valid_o) got_q.push_back('{d: bus.data_o, f: bus.frame_err_o, p: bus.parity_err_o});
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic bit_period(input logic v);
    rx = v;
    repeat (BT) @(posedge clk);
  endtask

  // Sends one frame and records what a correct receiver must report for it.
  task automatic send_frame(input logic [7:0] b, input logic stop, input logic par);
    frm_t e;
    e.d = b;
    e.f = ~stop;
`ifdef RX_PARITY_EN
    e.p = ($countones({b, par}) % 2) != 0;
`else
    e.p = 1'b0;
`endif
    exp_q.push_back(e);
    bit_period(1'b0);
    for (int i = 0; i < DB; i++) bit_period(b[i]);
`ifdef RX_PARITY_EN
    bit_period(par);
`endif
    bit_period(stop);
    rx = 1'b1;
  endtask

  task automatic check_frames(input string tag);
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      frm_t g, e;
      g = got_q.pop_front();
      e = exp_q.pop_front();
      chk({tag, "_data"}, g.d, e.d);
      chk({tag, "_ferr"}, g.f, e.f);
      chk({tag, "_perr"}, g.p, e.p);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_data"},  bus.data_o, 8'h00);
    chk({tag, "_valid"}, bus.valid_o, 1'b0);
    chk({tag, "_ferr"},  bus.frame_err_o, 1'b0);
    chk({tag, "_perr"},  bus.parity_err_o, 1'b0);
    chk({tag, "_busy"},  bus.busy_o, 1'b0);
    chk({tag, "_en"},    bus.cnt_en_o, 1'b0);
    chk({tag, "_clr"},   bus.cnt_clr_o, 1'b1);
    chk({tag, "_vmax"},  bus.cnt_vmax_o, BT / 2 - 1);
  endtask

  function automatic logic odd_par(input logic [7:0] b);
    return ($countones(b) % 2) != 0;
  endfunction

  initial begin
    repeat (3) @(posedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset");

    // Clean 0xA5, busy must drop before the stop bit ends.
    @(posedge clk);
    send_frame(8'hA5, 1'b1, odd_par(8'hA5));
    @(negedge clk);
    chk("a5_busy_after_stop", bus.busy_o, 1'b0);
    repeat (8) @(posedge clk);
    check_frames("a5");

    // Framing error then a good frame clears the flag.
    send_frame(8'h3C, 1'b0, odd_par(8'h3C));
    repeat (40) @(posedge clk);
    check_frames("3c_ferr");
    send_frame(8'h81, 1'b1, odd_par(8'h81));
    repeat (8) @(posedge clk);
    check_frames("81");

    // Short low glitch is rejected.
    rx = 1'b0;
    repeat (5) @(posedge clk);
    rx = 1'b1;
    repeat (40) @(posedge clk);
    @(negedge clk);
    chk("glitch_busy", bus.busy_o, 1'b0);
    chk("glitch_clr", bus.cnt_clr_o, 1'b1);
    check_frames("glitch");

    // Back-to-back frames with no idle gap.
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    repeat (8) @(posedge clk);
    check_frames("b2b");

    // Reset in the middle of data bit 3 of 0x5A.
    bit_period(1'b0);
    for (int i = 0; i < 3; i++) bit_period(1'(8'h5A >> i));
    rx = 1'b1;
    repeat (BT / 2) @(posedge clk);
    rst = 1'b1;
    @(posedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("midrst");
    repeat (200) @(posedge clk);
    check_frames("midrst_none");
    send_frame(8'h12, 1'b1, odd_par(8'h12));
    repeat (8) @(posedge clk);
    check_frames("after_rst");

`ifdef RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b1);
    repeat (8) @(posedge clk);
    check_frames("par_good");
    send_frame(8'h07, 1'b1, 1'b0);
    repeat (8) @(posedge clk);
    check_frames("par_bad");
`endif

    // Randomized frames, mostly with valid stop bits.
    for (int n = 0; n < 8; n++) begin
      logic [7:0] b;
      logic       s, p;
      b = 8'($urandom);
      s = ($urandom_range(0, 3) != 0);
      p = 1'($urandom);
      send_frame(b, s, p);
      repeat (40) @(posedge clk);
      check_frames("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
- Receive-path sequencer for the RS232 RX block.
- Owns the UART frame state machine and drives the shared baud tick counter (the counter_rx instance) through its enable, terminal-count and clear inputs.
- Synchronises the serial line, samples each bit mid-period and shifts out data bits LSB first.
- Presents the received byte with a one-cycle valid pulse and a framing-error flag.

Parameters:
- Width, 15, width of the baud counter terminal-count bus; must match the counter instance.
- BitTicks, 5208, clk_i cycles per bit (50 MHz / 9600 baud); legal range 4 to 2^Width-1.
- DataBits, 8, data bits per frame; legal range 5 to 8.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  synchronous, active-high reset.
- rx_i  in  1  asynchronous serial line; idles high.
- cnt_flag_i  in  1  counter terminal-count flag (counter value == cnt_vmax_o).
- cnt_en_o  out  1  counter enable.
- cnt_clr_o  out  1  counter clear; wired to the counter reset input.
- cnt_vmax_o  out  Width  counter terminal count.
- data_o  out  8  received byte; unused MSBs are 0 when DataBits < 8.
- valid_o  out  1  one-cycle pulse when data_o is updated.
- frame_err_o  out  1  stop bit sampled low for the most recent frame.
- parity_err_o  out  1  parity mismatch; see Optional Feature.
- busy_o  out  1  high when a frame is in progress.

Behaviour:
- Clock and reset: single clock; reset is synchronous and active-high. All state is updated only on the rising edge of clk_i.
- Reset values:
  - state = IDLE.
  - 2-flop rx synchroniser = 1,1.
  - data_o, shift register, bit index = 0.
  - valid_o, frame_err_o, parity_err_o = 0.
  - busy_o = 0, cnt_en_o = 0, cnt_clr_o = 1.
  - cnt_vmax_o = HALF, where HALF = BitTicks/2 - 1 (integer division) and FULL = BitTicks - 1.
- rx_s is rx_i after the 2-flop synchroniser. All decisions use rx_s only.
- A "tick" is a cycle in which cnt_en_o = 1 and cnt_flag_i = 1. On that cycle the counter wraps to 0.
- Counter-control outputs are decoded from the registered state only:
  - IDLE: clr = 1, en = 0, vmax = HALF.
  - START: clr = 0, en = 1, vmax = HALF.
  - DATA, PARITY, STOP: clr = 0, en = 1, vmax = FULL.
- busy_o = 1 in every state except IDLE.
- IDLE: rx_s = 0 moves to START. The counter is guaranteed to be 0 on entry to START.
- START: on a tick, sample rx_s.
  - rx_s = 0: go to DATA, bit index = 0.
  - rx_s = 1 (glitch): return to IDLE; no outputs change.
- DATA: on a tick, shift rx_s into the MSB of a DataBits-wide shift register (LSB-first frame) and increment the bit index.
  - After the tick with index = DataBits-1, go to PARITY if enabled, otherwise STOP.
- STOP: on a tick:
  - data_o <= shift register, zero-extended to 8 bits.
  - frame_err_o <= ~rx_s.
  - valid_o = 1 in the following cycle only.
  - Go to IDLE.
- frame_err_o and parity_err_o hold their value until the next valid_o.
- Timing:
  - Start-bit sample lands HALF+1 cycles after the START entry.
  - Each later sample lands exactly BitTicks cycles after the previous one.
  - valid_o rises one cycle after the stop-bit tick.
- Back-to-back frames: the controller returns to IDLE half a bit before the stop-bit end. A start edge immediately after the stop bit is accepted, with no lost frame.
- rx_s low in IDLE with the line stuck low (break): each attempt passes START, runs a full frame and reports frame_err_o = 1. No lock-up.
- rst_i asserted mid-frame: next cycle, state = IDLE and all outputs are at their reset values. No valid_o is issued for the aborted frame.
- cnt_flag_i outside START, DATA, PARITY and STOP is ignored.

Optional Feature:
- Macro: RX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP (vmax = FULL).
  - On its tick, the sampled bit is checked for even parity over the data bits plus the parity bit.
  - parity_err_o is updated together with data_o and valid_o.
  - Frame length becomes 1 + DataBits + 1 + 1 bits.
- Undefined:
  - No PARITY state.
  - parity_err_o is tied to 0.

Test Plan:
- Byte 0xA5 with BitTicks=16, 8N1, valid stop bit -> exactly one valid_o pulse, data_o=0xA5, frame_err_o=0; busy_o low again before the stop bit ends.
- Byte 0x3C with the stop bit driven low -> valid_o pulse, data_o=0x3C, frame_err_o=1; a following good frame 0x81 -> frame_err_o=0.
- rx_i low for 5 cycles (less than HALF+1=8) from idle, BitTicks=16 -> no valid_o; busy_o returns to 0; cnt_clr_o=1 in IDLE.
- Back-to-back 0x00 then 0xFF, with the next start bit immediately after the stop bit -> two valid_o pulses in order, both with frame_err_o=0.
- rst_i for 1 cycle in the middle of data bit 3 of 0x5A -> no valid_o; all outputs at reset values next cycle; following frame 0x12 received correctly.
- With RX_PARITY_EN: 0x07 with parity bit 1 -> parity_err_o=0; 0x07 with parity bit 0 -> parity_err_o=1.
